// File: rtl/data_sram_responder.sv
// Target side of the CPU data-SRAM port: word RAM plus a 16-byte MMIO window
// (timer, LED, scratch, display). Responses land on data_sram_rdata one cycle after the request.
module data_sram_responder #(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000,
   parameter logic [31:0] TIMER_INC = 32'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   output logic [31:0] num_data,
   output logic [31:0] timer
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [DEPTH];

   logic [31:0]       rdata_q, rdata_d;
   logic [15:0]       led_q, led_d;
   logic [31:0]       num_q, num_d;
   logic [31:0]       timer_q, timer_d;
   logic [31:0]       scratch_q, scratch_d;

   logic              mmio_hit;
   logic [1:0]        mmio_off;
   logic [ADDR_W-1:0] idx;
   logic              is_write;
   logic [31:0]       mmio_word;
   logic [31:0]       old_word;
   logic [31:0]       merged;
   logic              mem_we;
   logic              addr_unused;

   // Byte offset within a word carries no meaning on a word-addressed port.
   assign addr_unused = ^data_sram_addr[1:0];

   // Decode, byte merge and next-state for every register.
   always_comb begin
      mmio_hit  = (data_sram_addr[31:4] == MMIO_BASE[31:4]);
      mmio_off  = data_sram_addr[3:2];
      idx       = data_sram_addr[ADDR_W+1:2];
      is_write  = |data_sram_we;

      case (mmio_off)
         2'd0:    mmio_word = timer_q;
         2'd1:    mmio_word = {16'h0000, led_q};
         2'd2:    mmio_word = scratch_q;
         default: mmio_word = num_q;
      endcase

      old_word = mmio_hit ? mmio_word : mem[idx];
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = data_sram_we[i] ? data_sram_wdata[8*i +: 8] : old_word[8*i +: 8];
      end

      rdata_d   = rdata_q;
      led_d     = led_q;
      num_d     = num_q;
      scratch_d = scratch_q;
      timer_d   = timer_q + TIMER_INC;
      mem_we    = 1'b0;

      if (data_sram_en) begin
         // Write-first: a write returns the merged word it stores.
         rdata_d = is_write ? merged : old_word;
         if (is_write) begin
            if (mmio_hit) begin
               case (mmio_off)
                  2'd0:    timer_d   = merged;
                  2'd1:    led_d     = merged[15:0];
                  2'd2:    scratch_d = merged;
                  default: num_d     = merged;
               endcase
            end else begin
               mem_we = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q   <= 32'h0;
         led_q     <= 16'h0;
         num_q     <= 32'h0;
         timer_q   <= 32'h0;
         scratch_q <= 32'h0;
      end else begin
         rdata_q   <= rdata_d;
         led_q     <= led_d;
         num_q     <= num_d;
         timer_q   <= timer_d;
         scratch_q <= scratch_d;
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx] <= merged;
      end
   end

   assign data_sram_rdata = rdata_q;
   assign led             = led_q;
   assign num_data        = num_q;
   assign timer           = timer_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized bench for data_sram_responder against a word/register-level model,
// with directed scenarios that pin the model to literal values.
module tb_data_sram_responder;

   localparam logic [31:0] MMIO = 32'hBFAF_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        data_sram_en = 1'b0;
   logic [3:0]  data_sram_we = 4'h0;
   logic [31:0] data_sram_addr = 32'h0;
   logic [31:0] data_sram_wdata = 32'h0;
   logic [31:0] data_sram_rdata;
   logic [15:0] led;
   logic [31:0] num_data;
   logic [31:0] timer;

   int checks = 0;
   int errors = 0;

   bit [31:0] m_mem [4096];
   bit [31:0] m_rdata, m_num, m_timer, m_scratch;
   bit [15:0] m_led;

   data_sram_responder dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .led             (led),
      .num_data        (num_data),
      .timer           (timer)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] we);
      bit [31:0] r = old;
      for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_rdata = 0; m_led = 0; m_num = 0; m_timer = 0; m_scratch = 0;
   endtask

   // One clock edge of the reference: what each request means in register/word terms.
   task automatic model_step(input bit en, input bit [3:0] we, input bit [31:0] addr, input bit [31:0] wd);
      bit [31:0] old, nw, next_timer;
      bit        hit = (addr[31:4] == MMIO[31:4]);
      int        off = int'(addr[3:2]);
      int        ix  = int'(addr[13:2]);
      next_timer = m_timer + 32'd1;
      if (en) begin
         if (hit) old = (off == 0) ? m_timer : (off == 1) ? {16'h0, m_led} : (off == 2) ? m_scratch : m_num;
         else     old = m_mem[ix];
         nw = merge(old, wd, we);
         m_rdata = nw;
         if (we != 0) begin
            if (!hit) m_mem[ix] = nw;
            else if (off == 0) next_timer = nw;
            else if (off == 1) m_led = nw[15:0];
            else if (off == 2) m_scratch = nw;
            else m_num = nw;
         end
      end
      m_timer = next_timer;
   endtask

   task automatic compare_model();
      check("rdata", data_sram_rdata, m_rdata);
      check("led", {16'h0, led}, {16'h0, m_led});
      check("num_data", num_data, m_num);
      check("timer", timer, m_timer);
   endtask

   task automatic do_cycle(input bit en, input bit [3:0] we, input bit [31:0] addr, input bit [31:0] wd);
      data_sram_en = en; data_sram_we = we; data_sram_addr = addr; data_sram_wdata = wd;
      @(posedge clk);
      model_step(en, we, addr, wd);
      #1;
      compare_model();
   endtask

   initial begin
      bit [31:0] a, w;
      bit [3:0]  we;
      bit        en;

      repeat (2) @(posedge clk);
      #1;
      check("reset_rdata", data_sram_rdata, 32'h0);
      check("reset_led", {16'h0, led}, 32'h0);
      check("reset_num", num_data, 32'h0);
      check("reset_timer", timer, 32'h0);
      model_reset();
      rst = 1'b0;

      do_cycle(1, 4'hF, 32'h0000_0014, 32'hDEAD_BEEF);
      check("t1_write_first", data_sram_rdata, 32'hDEAD_BEEF);
      do_cycle(1, 4'h0, 32'h0000_0014, 32'h0);
      check("t1_read", data_sram_rdata, 32'hDEAD_BEEF);

      do_cycle(1, 4'hF, 32'h0000_001C, 32'h1122_3344);
      do_cycle(1, 4'b0101, 32'h0000_001C, 32'hAABB_CCDD);
      check("t2_merge_write", data_sram_rdata, 32'h11BB_33DD);
      do_cycle(1, 4'h0, 32'h0000_001C, 32'h0);
      check("t2_merge_read", data_sram_rdata, 32'h11BB_33DD);

      do_cycle(1, 4'hF, 32'h0000_0010, 32'h0000_0001);
      do_cycle(1, 4'h0, 32'h0000_4010, 32'h0);
      check("t3_alias", data_sram_rdata, 32'h0000_0001);

      do_cycle(1, 4'hF, MMIO + 32'h4, 32'hFFFF_A5A5);
      check("t4_led", {16'h0, led}, 32'h0000_A5A5);
      do_cycle(1, 4'h0, MMIO + 32'h4, 32'h0);
      check("t4_led_read", data_sram_rdata, 32'h0000_A5A5);

      do_cycle(1, 4'hF, MMIO, 32'hFFFF_FFFE);
      check("t5_timer_load", timer, 32'hFFFF_FFFE);
      do_cycle(0, 4'h0, 32'h0, 32'h0);
      do_cycle(1, 4'h0, MMIO, 32'h0);
      check("t5_timer_read", data_sram_rdata, 32'hFFFF_FFFF);
      check("t5_timer_wrap", timer, 32'h0);
      do_cycle(0, 4'h0, 32'h0, 32'h0);
      check("t5_timer_after", timer, 32'h1);

      do_cycle(1, 4'hF, MMIO + 32'hC, 32'h0BAD_F00D);
      check("t6_num", num_data, 32'h0BAD_F00D);
      do_cycle(1, 4'hF, 32'h0000_0024, 32'h0000_1234);
      do_cycle(1, 4'h0, 32'h0000_0024, 32'h0);
      for (int i = 0; i < 3; i++) begin
         do_cycle(0, 4'h0, 32'h0000_0024, 32'h0);
         check("t6_hold", data_sram_rdata, 32'h0000_1234);
      end
      #3;
      rst = 1'b1;
      #1;
      check("t6_async_rdata", data_sram_rdata, 32'h0);
      check("t6_async_led", {16'h0, led}, 32'h0);
      check("t6_async_num", num_data, 32'h0);
      check("t6_async_timer", timer, 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      compare_model();

      // Fill the region used by random traffic so no read returns uninitialised RAM.
      for (int i = 0; i < 64; i++) do_cycle(1, 4'hF, 32'(i) << 2, $urandom);

      for (int n = 0; n < 2000; n++) begin
         en = ($urandom_range(0, 99) < 85);
         we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         w  = $urandom;
         if ($urandom_range(0, 99) < 15) begin
            a = {MMIO[31:4], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         end else begin
            a = {18'($urandom), 6'h00, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            if (a[31:4] == MMIO[31:4]) a[31] = 1'b0;
         end
         do_cycle(en, we, a, w);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
